// File: rtl/lcd_ctrl.sv
// Write sequencer for an HD44780-compatible 8-bit character LCD.
// Runs the power-on init by itself, then writes one command/data byte per valid/ready handshake.
module lcd_ctrl #(
    parameter int T_PWR = 750000,
    parameter int T_AS  = 3,
    parameter int T_PW  = 25,
    parameter int T_H   = 3,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    input  logic        req_rs,
    input  logic [7:0]  req_data,
    output logic        req_rdy,
    output logic        init_done,
    output logic        lcd_on,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data,
    output logic [31:0] io_lcd
);

    // state    | meaning
    // PWR_WAIT | power-on delay before the first init byte
    // SETUP    | RS/DATA driven, EN low (address setup)
    // PULSE    | EN high
    // HOLD     | EN low, RS/DATA held
    // EXEC     | waiting for the LCD to execute the byte
    // IDLE     | ready for a request, RS/DATA keep the last byte

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max_of(max_of(max_of(T_PWR, T_AS), max_of(T_PW, T_H)),
                                 max_of(T_CMD, T_CLR));
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] LD_PWR = CW'(T_PWR - 1);
    localparam logic [CW-1:0] LD_AS  = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_PW  = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_H   = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_CMD = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLR = CW'(T_CLR - 1);

    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_PULSE    = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_IDLE     = 3'd5;

    localparam logic [2:0] LAST_INIT  = 3'd5;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          on_q;
    logic          done_q;
    logic          en_q;
    logic          tc;
    logic          is_clr;
    logic [CW-1:0] ld_exec;

    assign tc      = (cnt == '0);
    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign is_clr  = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign ld_exec = is_clr ? LD_CLR : LD_CMD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_PWR_WAIT;
            cnt      <= '0;
            init_idx <= 3'd0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            on_q     <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            on_q <= 1'b1;
            case (state)
                S_PWR_WAIT: begin
                    // The first edge after release only arms the power-on timer.
                    if (!on_q) begin
                        cnt <= LD_PWR;
                    end else if (tc) begin
                        state    <= S_SETUP;
                        cnt      <= LD_AS;
                        init_idx <= 3'd0;
                        rs_q     <= 1'b0;
                        data_q   <= init_byte(3'd0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SETUP: begin
                    if (tc) begin
                        state <= S_PULSE;
                        cnt   <= LD_PW;
                        en_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (tc) begin
                        state <= S_HOLD;
                        cnt   <= LD_H;
                        en_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tc) begin
                        state <= S_EXEC;
                        cnt   <= ld_exec;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (tc) begin
                        if (!done_q && (init_idx != LAST_INIT)) begin
                            state    <= S_SETUP;
                            cnt      <= LD_AS;
                            init_idx <= init_idx + 3'd1;
                            rs_q     <= 1'b0;
                            data_q   <= init_byte(init_idx + 3'd1);
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_vld) begin
                        state  <= S_SETUP;
                        cnt    <= LD_AS;
                        rs_q   <= req_rs;
                        data_q <= req_data;
                    end
                end
                default: begin
                    state <= S_PWR_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign req_rdy   = (state == S_IDLE);
    assign init_done = done_q;
    assign lcd_on    = on_q;
    assign lcd_en    = en_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = data_q;
    assign io_lcd    = {lcd_on, 20'b0, lcd_en, lcd_rs, lcd_rw, lcd_data};

endmodule
